uart_frame_loader: RTL

//  Consumes bytes from the UART receiver and assembles one image frame into the frame buffer.

---
 rtl/uart_frame_loader_pkg.sv | 20 ++
 rtl/uart_frame_loader_if.sv | 25 ++
 rtl/uart_frame_loader_strobe.sv | 29 ++
 rtl/uart_frame_loader.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/uart_frame_loader_pkg.sv
// rtl/uart_frame_loader_pkg.sv - shared state, sync-byte and error encodings for the frame loader
package uart_frame_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC1,
      ST_HI,
      ST_LO,
      ST_CKSUM
   } state_t;

   localparam logic [7:0] SYNC0_BYTE = 8'hAA;
   localparam logic [7:0] SYNC1_BYTE = 8'h55;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_CKSUM   = 2'd1;
   localparam logic [1:0] ERR_UART    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_frame_loader_if.sv
// rtl/uart_frame_loader_if.sv - receiver byte stream in, frame-buffer writes and frame status out
interface uart_frame_loader_if #(
   parameter int ADDR_W = 17
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ferr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              busy;
   logic              frame_done;
   logic              frame_ok;
   logic [1:0]        err_code;

   modport master (
      output rx_data, rx_valid, rx_ferr,
      input  wr_en, wr_addr, wr_data, busy, frame_done, frame_ok, err_code
   );

   modport slave (
      input  rx_data, rx_valid, rx_ferr,
      output wr_en, wr_addr, wr_data, busy, frame_done, frame_ok, err_code
   );
endinterface

// File: rtl/uart_frame_loader_strobe.sv
// rtl/uart_frame_loader_strobe.sv - uart_byte_strobe: one registered accept per rx_valid rise
module uart_byte_strobe (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_ferr,
   output logic       acc_valid,
   output logic [7:0] acc_data,
   output logic       acc_ferr
);

   logic valid_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid_q   <= 1'b0;
         acc_valid <= 1'b0;
         acc_data  <= 8'h00;
         acc_ferr  <= 1'b0;
      end else begin
         valid_q   <= rx_valid;
         acc_valid <= rx_valid & ~valid_q;
         acc_data  <= rx_data;
         acc_ferr  <= rx_ferr;
      end
   end

endmodule

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - sync hunt, RGB565 packing, frame-buffer writes, checksum and timeout
module uart_frame_loader
   import uart_frame_loader_pkg::*;
#(
   parameter int PIXELS  = 76800,
   parameter int ADDR_W  = 17,
   parameter int TIMEOUT = 5000000
) (
   input  logic clock,
   input  logic reset_n,
   uart_frame_loader_if.slave bus
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIXELS - 1);

   logic              acc_valid;
   logic [7:0]        acc_data;
   logic              acc_ferr;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pix_idx;
   logic [7:0]        sum;
   logic [7:0]        hi_byte;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              busy;

   logic              start, latch_hi, write_px, finish;
   logic [1:0]        finish_err;

   logic              wr_en_q, frame_done_q, frame_ok_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [15:0]       wr_data_q;
   logic [1:0]        err_code_q;

   uart_byte_strobe u_strobe (
      .clock     (clock),
      .reset_n   (reset_n),
      .rx_data   (bus.rx_data),
      .rx_valid  (bus.rx_valid),
      .rx_ferr   (bus.rx_ferr),
      .acc_valid (acc_valid),
      .acc_data  (acc_data),
      .acc_ferr  (acc_ferr)
   );

   assign busy = (state != ST_IDLE);

   // A byte accept always takes priority over a timeout landing on the same cycle.
   always_comb begin
      state_n    = state;
      start      = 1'b0;
      latch_hi   = 1'b0;
      write_px   = 1'b0;
      finish     = 1'b0;
      finish_err = ERR_NONE;
      if (acc_valid) begin
         if (acc_ferr && busy) begin
            state_n    = ST_IDLE;
            finish     = 1'b1;
            finish_err = ERR_UART;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (!acc_ferr && acc_data == SYNC0_BYTE) state_n = ST_SYNC1;
               end
               ST_SYNC1: begin
                  if (acc_data == SYNC1_BYTE) begin
                     state_n = ST_HI;
                     start   = 1'b1;
                  end else if (acc_data != SYNC0_BYTE) begin
                     state_n = ST_IDLE;
                  end
               end
               ST_HI: begin
                  latch_hi = 1'b1;
                  state_n  = ST_LO;
               end
               ST_LO: begin
                  write_px = 1'b1;
                  state_n  = (pix_idx == PIX_LAST) ? ST_CKSUM : ST_HI;
               end
               ST_CKSUM: begin
                  state_n    = ST_IDLE;
                  finish     = 1'b1;
                  finish_err = (acc_data == sum) ? ERR_NONE : ERR_CKSUM;
               end
               default: state_n = ST_IDLE;
            endcase
         end
      end else if (busy && tmo_cnt == TMO_LAST) begin
         state_n    = ST_IDLE;
         finish     = 1'b1;
         finish_err = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         pix_idx      <= '0;
         sum          <= 8'h00;
         hi_byte      <= 8'h00;
         tmo_cnt      <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 16'h0000;
         frame_done_q <= 1'b0;
         frame_ok_q   <= 1'b0;
         err_code_q   <= ERR_NONE;
      end else begin
         state        <= state_n;
         wr_en_q      <= write_px;
         frame_done_q <= finish;
         tmo_cnt      <= (acc_valid || !busy) ? '0 : tmo_cnt + 1'b1;
         if (start) begin
            pix_idx    <= '0;
            sum        <= 8'h00;
            err_code_q <= ERR_NONE;
         end
         if (latch_hi) begin
            hi_byte <= acc_data;
            sum     <= sum + acc_data;
         end
         if (write_px) begin
            wr_addr_q <= pix_idx;
            wr_data_q <= {hi_byte, acc_data};
            sum       <= sum + acc_data;
            pix_idx   <= pix_idx + 1'b1;
         end
         if (finish) begin
            err_code_q <= finish_err;
            frame_ok_q <= (finish_err == ERR_NONE);
         end
      end
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.busy       = busy;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_ok   = frame_ok_q;
   assign bus.err_code   = err_code_q;

endmodule
